uart_word_tx: RTL and testbench

UART_WORD_TX -- requirements
Module: uart_word_tx

---
 rtl/uart_word_tx.sv | 182 ++++++++++++++++++
 tb/tb_uart_word_tx.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_tx.sv
// uart_word_tx: word-wide UART transmitter fed by a small word FIFO.
// Define UART_WORD_TX_PARITY_EN to append an even-parity bit to every frame.
`timescale 1ns/1ps
module uart_word_tx #(
    parameter int SYS_CLK_FREQ   = 100,
    parameter int BAUDRATE       = 921600,
    parameter int W_D            = 32,
    parameter int FIFO_AW        = 2,
    parameter int MSB_BYTE_FIRST = 0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [W_D-1:0]   D,
    input  logic             ENQ,
    output logic             FULL,
    output logic             EMPTY,
    output logic [FIFO_AW:0] COUNT,
    output logic             BUSY,
    output logic             TXD
);

    localparam int SERIAL_WCNT = (SYS_CLK_FREQ * 1000000) / BAUDRATE;
    localparam int CW          = (SERIAL_WCNT > 1) ? $clog2(SERIAL_WCNT) : 1;
    localparam int NBYTES      = W_D / 8;
    localparam int DEPTH       = 1 << FIFO_AW;

    localparam logic [CW-1:0]    BIT_LOAD  = CW'(SERIAL_WCNT - 1);
    localparam logic [2:0]       BYTE_LAST = 3'(NBYTES - 1);
    localparam logic [FIFO_AW:0] DEPTH_C   = {1'b1, {FIFO_AW{1'b0}}};

`ifdef UART_WORD_TX_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_PARITY = 3'd4;
    localparam logic [2:0] S_STOP   = 3'd5;

    logic [W_D-1:0]     mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   cnt_nxt;
    logic               push, pop;

    logic [2:0]         state;
    logic [CW-1:0]      bit_cnt;
    logic [2:0]         bit_idx;
    logic [2:0]         byte_cnt;
    logic [W_D-1:0]     word_sr;
    logic [7:0]         cur_byte;
    logic               bit_tc;

    // ENQ is refused while full even if LOAD frees a slot on the same edge
    assign push = ENQ && !FULL;
    assign pop  = (state == S_LOAD);

    always_comb begin
        cnt_nxt = COUNT;
        if (push && !pop)
            cnt_nxt = COUNT + 1'b1;
        else if (pop && !push)
            cnt_nxt = COUNT - 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= D;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            COUNT  <= '0;
            FULL   <= 1'b0;
            EMPTY  <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            COUNT <= cnt_nxt;
            FULL  <= (cnt_nxt == DEPTH_C);
            EMPTY <= (cnt_nxt == '0);
        end
    end

    assign cur_byte = (MSB_BYTE_FIRST != 0) ? word_sr[W_D-1 -: 8] : word_sr[7:0];
    assign bit_tc   = (bit_cnt == '0);
    assign BUSY     = (state != S_IDLE);

    // TXD is registered and updated on the edge that enters each bit
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            byte_cnt <= '0;
            word_sr  <= '0;
            TXD      <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    TXD <= 1'b1;
                    if (!EMPTY)
                        state <= S_LOAD;
                end
                S_LOAD: begin
                    word_sr  <= mem[rd_ptr];
                    byte_cnt <= BYTE_LAST;
                    bit_cnt  <= BIT_LOAD;
                    TXD      <= 1'b0;
                    state    <= S_START;
                end
                S_START: begin
                    if (bit_tc) begin
                        bit_idx <= '0;
                        bit_cnt <= BIT_LOAD;
                        TXD     <= cur_byte[0];
                        state   <= S_DATA;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_tc) begin
                        bit_cnt <= BIT_LOAD;
                        if (bit_idx == 3'd7) begin
                            if (PARITY_EN) begin
                                TXD   <= ^cur_byte;
                                state <= S_PARITY;
                            end else begin
                                TXD   <= 1'b1;
                                state <= S_STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            TXD     <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                S_PARITY: begin
                    if (bit_tc) begin
                        bit_cnt <= BIT_LOAD;
                        TXD     <= 1'b1;
                        state   <= S_STOP;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_tc) begin
                        if (byte_cnt != '0) begin
                            byte_cnt <= byte_cnt - 1'b1;
                            word_sr  <= (MSB_BYTE_FIRST != 0) ? (word_sr << 8) : (word_sr >> 8);
                            bit_cnt  <= BIT_LOAD;
                            TXD      <= 1'b0;
                            state    <= S_START;
                        end else if (!EMPTY) begin
                            state <= S_LOAD;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                default: begin
                    TXD   <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: directed bench for uart_word_tx at 10 clocks per bit.
// Follows UART_WORD_TX_PARITY_EN to expect 10- or 11-bit frames.
`timescale 1ns/1ps
module tb_uart_word_tx;

    localparam int WCNT = 10;
`ifdef UART_WORD_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [31:0] d = '0, d_m = '0;
    logic        enq = 1'b0, enq_m = 1'b0;
    logic        full, empty, busy, txd;
    logic [2:0]  count;
    logic        full_m, empty_m, busy_m, txd_m;
    logic [2:0]  count_m;

    int vectors = 0;
    int errors  = 0;

    always #5 CLK = ~CLK;

    uart_word_tx #(
        .SYS_CLK_FREQ(100), .BAUDRATE(10000000), .W_D(32), .FIFO_AW(2), .MSB_BYTE_FIRST(0)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .D(d), .ENQ(enq), .FULL(full), .EMPTY(empty),
        .COUNT(count), .BUSY(busy), .TXD(txd)
    );

    uart_word_tx #(
        .SYS_CLK_FREQ(100), .BAUDRATE(10000000), .W_D(32), .FIFO_AW(2), .MSB_BYTE_FIRST(1)
    ) dut_m (
        .CLK(CLK), .RST_N(RST_N), .D(d_m), .ENQ(enq_m), .FULL(full_m), .EMPTY(empty_m),
        .COUNT(count_m), .BUSY(busy_m), .TXD(txd_m)
    );

    // One-cycle ENQ pulse; returns just after the accepting edge.
    task automatic push_one(input bit sel, input logic [31:0] w);
        @(posedge CLK); #1;
        if (sel) begin enq_m = 1'b1; d_m = w; end
        else     begin enq   = 1'b1; d   = w; end
        @(posedge CLK); #1;
        enq   = 1'b0;
        enq_m = 1'b0;
    endtask

    // Walks a whole word cycle by cycle from the next falling edge, first start bit onward.
    task automatic check_word(input bit sel, input logic [31:0] w, input bit msb, input string name);
        logic [7:0] b;
        logic       fr [0:10];
        logic       s, bad_val;
        bit         bad;
        for (int by = 0; by < 4; by++) begin
            b = msb ? w[31 - 8*by -: 8] : w[8*by +: 8];
            fr[0] = 1'b0;
            for (int i = 0; i < 8; i++) fr[i+1] = b[i];
            if (FB == 11) fr[9] = ^b;
            fr[FB-1] = 1'b1;
            for (int bi = 0; bi < FB; bi++) begin
                bad = 1'b0;
                bad_val = 1'b0;
                for (int c = 0; c < WCNT; c++) begin
                    @(negedge CLK);
                    s = sel ? txd_m : txd;
                    if (s !== fr[bi]) begin bad = 1'b1; bad_val = s; end
                end
                vectors++;
                if (bad) begin
                    errors++;
                    $display("FAIL %s byte %0d bit %0d: TXD got %b, required %b for %0d cycles",
                             name, by, bi, bad_val, fr[bi], WCNT);
                end
            end
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        #12;
        vectors++; if (txd !== 1'b1)   begin errors++; $display("FAIL reset_txd: got %b, required 1", txd); end
        vectors++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b, required 1", empty); end
        vectors++; if (full !== 1'b0)  begin errors++; $display("FAIL reset_full: got %b, required 0", full); end
        vectors++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d, required 0", count); end
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);
        vectors++; if (txd !== 1'b1 || busy !== 1'b0)
            begin errors++; $display("FAIL post_reset_idle: txd/busy got %b%b, required 10", txd, busy); end
    endtask

    task automatic test_single_word();
        push_one(1'b0, 32'h12345678);
        @(negedge CLK);
        vectors++; if (count !== 3'd1) begin errors++; $display("FAIL single_count1: got %0d, required 1", count); end
        vectors++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty0: got %b, required 0", empty); end
        vectors++; if (busy !== 1'b0)  begin errors++; $display("FAIL single_idle_busy: got %b, required 0", busy); end
        @(negedge CLK);
        vectors++; if (busy !== 1'b1 || txd !== 1'b1)
            begin errors++; $display("FAIL single_load: busy/txd got %b%b, required 11", busy, txd); end
        check_word(1'b0, 32'h12345678, 1'b0, "single");
        @(negedge CLK);
        vectors++; if (busy !== 1'b0 || txd !== 1'b1 || empty !== 1'b1)
            begin errors++; $display("FAIL single_done: busy/txd/empty got %b%b%b, required 011", busy, txd, empty); end
    endtask

    task automatic test_msb_first();
        push_one(1'b1, 32'hA1B2C3D4);
        @(negedge CLK);
        @(negedge CLK);
        vectors++; if (busy_m !== 1'b1 || txd_m !== 1'b1)
            begin errors++; $display("FAIL msb_load: busy/txd got %b%b, required 11", busy_m, txd_m); end
        check_word(1'b1, 32'hA1B2C3D4, 1'b1, "msb");
        @(negedge CLK);
        vectors++; if (busy_m !== 1'b0 || empty_m !== 1'b1)
            begin errors++; $display("FAIL msb_done: busy/empty got %b%b, required 01", busy_m, empty_m); end
    endtask

    task automatic test_back_to_back();
        @(posedge CLK); #1;
        enq = 1'b1; d = 32'hCAFE0011;
        @(posedge CLK); #1;
        d = 32'h5A5AF00F;
        @(posedge CLK); #1;
        enq = 1'b0;
        @(negedge CLK);
        vectors++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_count2: got %0d, required 2", count); end
        check_word(1'b0, 32'hCAFE0011, 1'b0, "b2b_w1");
        @(negedge CLK);
        vectors++; if (txd !== 1'b1 || busy !== 1'b1 || count !== 3'd1)
            begin errors++; $display("FAIL b2b_gap: txd/busy/count got %b%b%0d, required 111", txd, busy, count); end
        check_word(1'b0, 32'h5A5AF00F, 1'b0, "b2b_w2");
        @(negedge CLK);
        vectors++; if (busy !== 1'b0 || empty !== 1'b1)
            begin errors++; $display("FAIL b2b_done: busy/empty got %b%b, required 01", busy, empty); end
    endtask

    task automatic test_full();
        logic [31:0] wl [0:4];
        wl[0] = 32'h11111111; wl[1] = 32'h22222222; wl[2] = 32'h33333333;
        wl[3] = 32'h44444444; wl[4] = 32'h55555555;
        push_one(1'b0, 32'h0F0F0F0F);
        @(negedge CLK);
        @(negedge CLK);
        fork
            check_word(1'b0, 32'h0F0F0F0F, 1'b0, "full_w0");
            begin
                enq = 1'b1; d = wl[0];
                for (int k = 0; k < 5; k++) begin
                    @(posedge CLK); #1;
                    if (k < 4) d = wl[k+1];
                    else       enq = 1'b0;
                    @(negedge CLK);
                    vectors++;
                    if (count !== ((k < 4) ? 3'(k + 1) : 3'd4)) begin
                        errors++;
                        $display("FAIL full_count_k%0d: got %0d, required %0d", k, count, (k < 4) ? k + 1 : 4);
                    end
                    vectors++;
                    if (full !== (k >= 3)) begin
                        errors++;
                        $display("FAIL full_flag_k%0d: got %b, required %b", k, full, (k >= 3));
                    end
                end
            end
        join
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            vectors++; if (txd !== 1'b1 || busy !== 1'b1)
                begin errors++; $display("FAIL full_load%0d: txd/busy got %b%b, required 11", i, txd, busy); end
            check_word(1'b0, wl[i], 1'b0, $sformatf("full_w%0d", i + 1));
        end
        @(negedge CLK);
        vectors++; if (busy !== 1'b0 || empty !== 1'b1)
            begin errors++; $display("FAIL full_dropped: busy/empty got %b%b, required 01", busy, empty); end
    endtask

    task automatic test_reset_mid();
        bit bad;
        push_one(1'b0, 32'hDEADBEEF);
        push_one(1'b0, 32'h01234567);
        repeat (25) @(negedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        vectors++; if (txd !== 1'b1)   begin errors++; $display("FAIL rstmid_txd: got %b, required 1", txd); end
        vectors++; if (busy !== 1'b0)  begin errors++; $display("FAIL rstmid_busy: got %b, required 0", busy); end
        vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty: got %b, required 1", empty); end
        vectors++; if (count !== 3'd0) begin errors++; $display("FAIL rstmid_count: got %0d, required 0", count); end
        @(negedge CLK);
        RST_N = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge CLK);
            if (txd !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        vectors++; if (bad) begin errors++; $display("FAIL rstmid_quiet: line activity after release, required idle"); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_msb_first();
        test_back_to_back();
        test_full();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
